// File: rtl/shk_bus_pkg.sv
// Shared shake-bus definitions: FSM state encoding, error flag positions,
// miss data fill and default widths used by the shake register slave.
package shk_bus_pkg;

    localparam int SHK_WD_DATA_DEF      = 16;
    localparam int SHK_WD_ADDR_DEF      = 16;
    localparam int SHK_NB_REG_ADDR_DEF  = 4;
    localparam int SHK_NB_RSP_DELAY_DEF = 2;
    localparam int SHK_WD_ERR_INFO_DEF  = 4;
    localparam int SHK_WD_DELAY_CNT     = 4;

    localparam int ERR_BIT_OVERRUN = 0;
    localparam int ERR_BIT_MISS    = 1;

    // Every bit of the returned data is set to this on an address miss.
    localparam logic SHK_MISS_FILL = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } shk_state_e;

    function automatic logic [SHK_WD_DELAY_CNT-1:0] delay_load(input int nb_rsp_delay);
        return (nb_rsp_delay == 0) ? '0 : SHK_WD_DELAY_CNT'(nb_rsp_delay - 1);
    endfunction

endpackage

// File: rtl/shk_reg_bank.sv
// Register storage for the shake slave: address decode, hit detection,
// write-through storage and a one-cycle registered one-hot write strobe.
module shk_reg_bank
    import shk_bus_pkg::*;
#(
    parameter int                     WD_SHK_DATA = SHK_WD_DATA_DEF,
    parameter int                     WD_SHK_ADDR = SHK_WD_ADDR_DEF,
    parameter int                     NB_REG_ADDR = SHK_NB_REG_ADDR_DEF,
    parameter logic [WD_SHK_ADDR-1:0] REG_BASE    = 'h0010
) (
    input  logic                                    i_sys_clk,
    input  logic                                    i_sys_reset,
    input  logic                                    wr_en,
    input  logic [WD_SHK_ADDR-1:0]                  acc_addr,
    input  logic [WD_SHK_DATA-1:0]                  wr_data,
    output logic                                    hit,
    output logic [WD_SHK_DATA-1:0]                  rd_data,
    output logic [(2**NB_REG_ADDR)*WD_SHK_DATA-1:0] reg_bank,
    output logic [(2**NB_REG_ADDR)-1:0]             reg_wstb
);

    localparam int NUM_REGS = 2**NB_REG_ADDR;

    logic [WD_SHK_ADDR-1:0] offset;
    logic [NB_REG_ADDR-1:0] index;
    logic [WD_SHK_DATA-1:0] regs_q [NUM_REGS];

    // Offset is only trusted once the address is known to be at or above the
    // base, so the subtraction can never wrap into the window.
    assign offset  = acc_addr - REG_BASE;
    assign index   = offset[NB_REG_ADDR-1:0];
    assign hit     = (acc_addr >= REG_BASE) && ((offset >> NB_REG_ADDR) == '0);
    assign rd_data = regs_q[index];

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            logic                   sel;
            logic [WD_SHK_DATA-1:0] data_reg;
            logic                   wstb_reg;

            assign sel = wr_en && hit && (index == NB_REG_ADDR'(gi));

            always_ff @(posedge i_sys_clk or posedge i_sys_reset) begin
                if (i_sys_reset) begin
                    data_reg <= '0;
                    wstb_reg <= 1'b0;
                end else begin
                    wstb_reg <= sel;
                    if (sel) begin
                        data_reg <= wr_data;
                    end
                end
            end

            assign regs_q[gi]                            = data_reg;
            assign reg_wstb[gi]                          = wstb_reg;
            assign reg_bank[gi*WD_SHK_DATA +: WD_SHK_DATA] = data_reg;
        end
    endgenerate

endmodule

// File: rtl/shk_reg_slave.sv
// Shake-bus responder terminating master requests into a local register bank.
// Define SHK_REG_SLAVE_ERR_INFO_EN to enable sticky overrun/miss flags on m_err_reg_info1.
module shk_reg_slave
    import shk_bus_pkg::*;
#(
    parameter int                     WD_SHK_DATA  = SHK_WD_DATA_DEF,
    parameter int                     WD_SHK_ADDR  = SHK_WD_ADDR_DEF,
    parameter int                     NB_REG_ADDR  = SHK_NB_REG_ADDR_DEF,
    parameter logic [WD_SHK_ADDR-1:0] REG_BASE     = 'h0010,
    parameter int                     NB_RSP_DELAY = SHK_NB_RSP_DELAY_DEF,
    parameter int                     WD_ERR_INFO  = SHK_WD_ERR_INFO_DEF
) (
    input  logic                                    i_sys_clk,
    input  logic                                    i_sys_reset,
    input  logic                                    s_shk_reg_valid,
    input  logic                                    s_shk_reg_msync,
    input  logic [WD_SHK_DATA-1:0]                  s_shk_reg_mdata,
    input  logic [WD_SHK_ADDR-1:0]                  s_shk_reg_maddr,
    output logic                                    s_shk_reg_ready,
    output logic                                    s_shk_reg_ssync,
    output logic [WD_SHK_DATA-1:0]                  s_shk_reg_sdata,
    output logic [WD_SHK_ADDR-1:0]                  s_shk_reg_saddr,
    output logic [(2**NB_REG_ADDR)*WD_SHK_DATA-1:0] o_reg_bank,
    output logic [(2**NB_REG_ADDR)-1:0]             o_reg_wstb,
    output logic [WD_ERR_INFO-1:0]                  m_err_reg_info1
);

    localparam logic [SHK_WD_DELAY_CNT-1:0] DELAY_LOAD = delay_load(NB_RSP_DELAY);
    localparam logic                        NO_DELAY   = (NB_RSP_DELAY == 0);

    shk_state_e                  state_reg;
    logic [SHK_WD_DELAY_CNT-1:0] cnt_reg;
    logic                        sync_reg;
    logic [WD_SHK_ADDR-1:0]      addr_reg;
    logic [WD_SHK_DATA-1:0]      data_reg;
    logic                        ready_reg;
    logic                        ssync_reg;
    logic [WD_SHK_DATA-1:0]      sdata_reg;
    logic [WD_SHK_ADDR-1:0]      saddr_reg;

    logic                   in_idle;
    logic                   go_resp;
    logic                   acc_write;
    logic [WD_SHK_ADDR-1:0] acc_addr;
    logic [WD_SHK_DATA-1:0] acc_data;
    logic                   hit;
    logic [WD_SHK_DATA-1:0] rd_data;
    logic [WD_SHK_DATA-1:0] resp_data;

    assign in_idle = (state_reg == ST_IDLE);

    // The access is performed on the edge that enters RESP; without a delay
    // that edge is the accepting one, so the live request is used directly.
    assign go_resp   = in_idle ? (s_shk_reg_valid && NO_DELAY)
                               : ((state_reg == ST_WAIT) && (cnt_reg == '0));
    assign acc_write = in_idle ? s_shk_reg_msync : sync_reg;
    assign acc_addr  = in_idle ? s_shk_reg_maddr : addr_reg;
    assign acc_data  = in_idle ? s_shk_reg_mdata : data_reg;

    always_comb begin
        resp_data = {WD_SHK_DATA{SHK_MISS_FILL}};
        if (hit) begin
            resp_data = acc_write ? acc_data : rd_data;
        end
    end

    shk_reg_bank #(
        .WD_SHK_DATA (WD_SHK_DATA),
        .WD_SHK_ADDR (WD_SHK_ADDR),
        .NB_REG_ADDR (NB_REG_ADDR),
        .REG_BASE    (REG_BASE)
    ) u_bank (
        .i_sys_clk   (i_sys_clk),
        .i_sys_reset (i_sys_reset),
        .wr_en       (go_resp && acc_write),
        .acc_addr    (acc_addr),
        .wr_data     (acc_data),
        .hit         (hit),
        .rd_data     (rd_data),
        .reg_bank    (o_reg_bank),
        .reg_wstb    (o_reg_wstb)
    );

    always_ff @(posedge i_sys_clk or posedge i_sys_reset) begin
        if (i_sys_reset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            sync_reg  <= 1'b0;
            addr_reg  <= '0;
            data_reg  <= '0;
            ready_reg <= 1'b0;
            ssync_reg <= 1'b0;
            sdata_reg <= '0;
            saddr_reg <= '0;
        end else begin
            ready_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (s_shk_reg_valid) begin
                        sync_reg <= s_shk_reg_msync;
                        addr_reg <= s_shk_reg_maddr;
                        data_reg <= s_shk_reg_mdata;
                        if (NO_DELAY) begin
                            state_reg <= ST_RESP;
                        end else begin
                            state_reg <= ST_WAIT;
                            cnt_reg   <= DELAY_LOAD;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt_reg == '0) begin
                        state_reg <= ST_RESP;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                ST_RESP: state_reg <= ST_IDLE;
                default: state_reg <= ST_IDLE;
            endcase
            // Response fields hold their value until the next acknowledge.
            if (go_resp) begin
                ready_reg <= 1'b1;
                ssync_reg <= acc_write;
                saddr_reg <= acc_addr;
                sdata_reg <= resp_data;
            end
        end
    end

    assign s_shk_reg_ready = ready_reg;
    assign s_shk_reg_ssync = ssync_reg;
    assign s_shk_reg_sdata = sdata_reg;
    assign s_shk_reg_saddr = saddr_reg;

`ifdef SHK_REG_SLAVE_ERR_INFO_EN
    logic [WD_ERR_INFO-1:0] err_reg;
    logic                   overrun;

    // Any strobe outside IDLE, including the acknowledge cycle, is dropped.
    assign overrun = s_shk_reg_valid && !in_idle;

    always_ff @(posedge i_sys_clk or posedge i_sys_reset) begin
        if (i_sys_reset) begin
            err_reg <= '0;
        end else begin
            if (overrun) begin
                err_reg[ERR_BIT_OVERRUN] <= 1'b1;
            end
            if (go_resp && !hit) begin
                err_reg[ERR_BIT_MISS] <= 1'b1;
            end
        end
    end

    assign m_err_reg_info1 = err_reg;
`else
    assign m_err_reg_info1 = '0;
`endif

endmodule

// File: tb/tb_shk_reg_slave.sv
// Bench for shk_reg_slave: a 2-cycle-delay and a zero-delay instance driven by
// the same directed and random requests, checked every cycle against a request-level model.
`timescale 1ns/1ps
module tb_shk_reg_slave;

`ifdef SHK_REG_SLAVE_ERR_INFO_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        valid = 1'b0;
    logic        msync = 1'b0;
    logic [15:0] maddr = '0;
    logic [15:0] mdata = '0;

    logic         a_ready, b_ready, a_ssync, b_ssync;
    logic [15:0]  a_sdata, b_sdata, a_saddr, b_saddr, a_wstb, b_wstb;
    logic [255:0] a_bank, b_bank;
    logic [3:0]   a_err, b_err;

    int errors  = 0;
    int checks  = 0;
    int cyc     = 0;
    bit started = 1'b0;

    // Request-level model, index 0 = delay 2, index 1 = delay 0.
    int          dly [2] = '{2, 0};
    logic [15:0] m_bank [2][16];
    bit          have_due [2];
    int          due [2];
    logic        pw [2];
    logic [15:0] pa [2];
    logic [15:0] pd [2];
    logic        x_ready [2];
    logic        x_ssync [2];
    logic [15:0] x_sdata [2];
    logic [15:0] x_saddr [2];
    logic [15:0] x_wstb [2];
    bit          x_ovr [2];
    bit          x_miss [2];

    shk_reg_slave #(.NB_RSP_DELAY(2)) u_dut (
        .i_sys_clk       (clk),
        .i_sys_reset     (rst),
        .s_shk_reg_valid (valid),
        .s_shk_reg_msync (msync),
        .s_shk_reg_mdata (mdata),
        .s_shk_reg_maddr (maddr),
        .s_shk_reg_ready (a_ready),
        .s_shk_reg_ssync (a_ssync),
        .s_shk_reg_sdata (a_sdata),
        .s_shk_reg_saddr (a_saddr),
        .o_reg_bank      (a_bank),
        .o_reg_wstb      (a_wstb),
        .m_err_reg_info1 (a_err)
    );

    shk_reg_slave #(.NB_RSP_DELAY(0)) u_dut0 (
        .i_sys_clk       (clk),
        .i_sys_reset     (rst),
        .s_shk_reg_valid (valid),
        .s_shk_reg_msync (msync),
        .s_shk_reg_mdata (mdata),
        .s_shk_reg_maddr (maddr),
        .s_shk_reg_ready (b_ready),
        .s_shk_reg_ssync (b_ssync),
        .s_shk_reg_sdata (b_sdata),
        .s_shk_reg_saddr (b_saddr),
        .o_reg_bank      (b_bank),
        .o_reg_wstb      (b_wstb),
        .m_err_reg_info1 (b_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d cyc=%0d got=%0h want=%0h", name, idx, cyc, act, exp);
        end
    endtask

    function automatic logic [3:0] exp_err(input int i);
        return ERR_ON ? {2'b00, x_miss[i], x_ovr[i]} : 4'h0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int r = 0; r < 16; r++) m_bank[i][r] = '0;
            have_due[i] = 1'b0;
            due[i]      = 0;
            x_ready[i]  = 1'b0;
            x_ssync[i]  = 1'b0;
            x_sdata[i]  = '0;
            x_saddr[i]  = '0;
            x_wstb[i]   = '0;
            x_ovr[i]    = 1'b0;
            x_miss[i]   = 1'b0;
        end
    endtask

    // Called right after each rising edge: consumes the request of cycle n and
    // produces what the outputs must show during cycle n+1.
    task automatic model_edge();
        int n;
        n = cyc;
        for (int i = 0; i < 2; i++) begin
            x_ready[i] = 1'b0;
            x_wstb[i]  = '0;
            if (valid) begin
                if (have_due[i] && n <= due[i]) begin
                    x_ovr[i] = 1'b1;
                end else begin
                    have_due[i] = 1'b1;
                    due[i]      = n + 1 + dly[i];
                    pw[i]       = msync;
                    pa[i]       = maddr;
                    pd[i]       = mdata;
                end
            end
            if (have_due[i] && due[i] == n + 1) begin
                int off;
                off        = int'(pa[i]) - 16;
                x_ready[i] = 1'b1;
                x_ssync[i] = pw[i];
                x_saddr[i] = pa[i];
                if (off >= 0 && off < 16) begin
                    if (pw[i]) begin
                        m_bank[i][off] = pd[i];
                        x_wstb[i]      = 16'(1 << off);
                    end
                    x_sdata[i] = m_bank[i][off];
                end else begin
                    x_sdata[i] = 16'hFFFF;
                    x_miss[i]  = 1'b1;
                end
            end
        end
        cyc++;
    endtask

    task automatic check_dut(input int i, input logic rdy, input logic ss, input logic [15:0] sd,
                             input logic [15:0] sa, input logic [15:0] ws, input logic [255:0] bk,
                             input logic [3:0] er);
        chk("ready", i, rdy, x_ready[i]);
        chk("ssync", i, ss, x_ssync[i]);
        chk("sdata", i, sd, x_sdata[i]);
        chk("saddr", i, sa, x_saddr[i]);
        chk("wstb",  i, ws, x_wstb[i]);
        chk("err",   i, er, exp_err(i));
        for (int r = 0; r < 16; r++) begin
            chk($sformatf("bank_reg%0d", r), i, bk[r*16 +: 16], m_bank[i][r]);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            check_dut(0, a_ready, a_ssync, a_sdata, a_saddr, a_wstb, a_bank, a_err);
            check_dut(1, b_ready, b_ssync, b_sdata, b_saddr, b_wstb, b_bank, b_err);
        end
    end

    task automatic step(input logic v, input logic s, input logic [15:0] a, input logic [15:0] d);
        valid = v;
        msync = s;
        maddr = a;
        mdata = d;
        @(posedge clk);
        if (rst) begin
            model_reset();
            cyc++;
        end else begin
            model_edge();
        end
        @(negedge clk);
    endtask

    task automatic idle(input int k);
        repeat (k) step(1'b0, 1'b0, 16'h0000, 16'h0000);
    endtask

    // Reset asserted between edges, held for 'hold' extra cycles, released on a falling edge.
    task automatic async_reset(input int hold);
        valid = 1'b0;
        msync = 1'b0;
        @(posedge clk);
        model_edge();
        #2 rst = 1'b1;
        model_reset();
        #1;
        chk("rst_ready", 0, a_ready, 0);
        chk("rst_sdata", 0, a_sdata, 0);
        chk("rst_saddr", 0, a_saddr, 0);
        chk("rst_bank",  0, 64'(|a_bank), 0);
        chk("rst_err",   0, a_err, 0);
        @(negedge clk);
        repeat (hold) idle(1);
        rst = 1'b0;
    endtask

    initial begin
        int r;
        logic [15:0] a;
        model_reset();
        repeat (3) @(negedge clk);
        started = 1'b1;
        rst     = 1'b0;

        // Write 0x1234 to 0x0013 in the first cycle out of reset.
        step(1'b1, 1'b1, 16'h0013, 16'h1234);
        chk("d0_ready", 1, b_ready, 1);
        chk("d0_sdata", 1, b_sdata, 16'h1234);
        chk("d0_wstb",  1, b_wstb, 16'h0008);
        chk("w_early",  0, a_ready, 0);
        idle(1);
        chk("w_early",  0, a_ready, 0);
        idle(1);
        chk("w_ready",  0, a_ready, 1);
        chk("w_ssync",  0, a_ssync, 1);
        chk("w_saddr",  0, a_saddr, 16'h0013);
        chk("w_sdata",  0, a_sdata, 16'h1234);
        chk("w_wstb",   0, a_wstb, 16'h0008);
        chk("w_reg3",   0, a_bank[63:48], 16'h1234);
        idle(1);
        chk("w_done",   0, a_ready, 0);
        chk("w_hold",   0, a_sdata, 16'h1234);
        chk("w_wstb0",  0, a_wstb, 0);

        // Read back.
        step(1'b1, 1'b0, 16'h0013, 16'h0000);
        idle(2);
        chk("r_ready",  0, a_ready, 1);
        chk("r_ssync",  0, a_ssync, 0);
        chk("r_sdata",  0, a_sdata, 16'h1234);
        chk("r_wstb",   0, a_wstb, 0);
        idle(1);

        // Miss.
        step(1'b1, 1'b1, 16'h0020, 16'hBEEF);
        idle(2);
        chk("m_ready",  0, a_ready, 1);
        chk("m_sdata",  0, a_sdata, 16'hFFFF);
        chk("m_saddr",  0, a_saddr, 16'h0020);
        chk("m_bank_lo", 0, a_bank[63:0], 64'h1234_0000_0000_0000);
        chk("m_bank_hi", 0, 64'(|a_bank[255:64]), 0);
        chk("m_err",    0, a_err, ERR_ON ? 4'b0010 : 4'b0000);
        idle(1);

        // Overrun: second valid during WAIT (delay 2) / RESP (delay 0).
        step(1'b1, 1'b0, 16'h0013, 16'h0000);
        step(1'b1, 1'b1, 16'h0014, 16'h5555);
        idle(1);
        chk("o_ready",  0, a_ready, 1);
        chk("o_sdata",  0, a_sdata, 16'h1234);
        chk("o_err",    0, a_err, ERR_ON ? 4'b0011 : 4'b0000);
        idle(1);
        chk("o_noready", 0, a_ready, 0);
        chk("o_reg4",   0, a_bank[79:64], 16'h0000);
        idle(1);

        // Reset while waiting; read 0x0010 in the first cycle after release.
        step(1'b1, 1'b1, 16'h0015, 16'hAAAA);
        async_reset(2);
        step(1'b1, 1'b0, 16'h0010, 16'h0000);
        chk("pr_b_sdata", 1, b_sdata, 16'h0000);
        idle(2);
        chk("pr_ready", 0, a_ready, 1);
        chk("pr_sdata", 0, a_sdata, 16'h0000);
        idle(1);

        // Zero-delay instance: requests two cycles apart, no overrun.
        step(1'b1, 1'b1, 16'h0011, 16'h0101);
        chk("z_ready1", 1, b_ready, 1);
        idle(1);
        chk("z_gap",    1, b_ready, 0);
        step(1'b1, 1'b1, 16'h0012, 16'h0202);
        chk("z_ready2", 1, b_ready, 1);
        chk("z_sdata2", 1, b_sdata, 16'h0202);
        idle(1);
        chk("z_noovr",  1, b_err[0], 0);
        idle(3);

        // Random traffic, mostly around the register window.
        for (int k = 0; k < 3000; k++) begin
            r = int'($urandom_range(0, 99));
            if (r == 0) begin
                async_reset(int'($urandom_range(0, 2)));
            end else begin
                a = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(8, 39));
                step(r < 45, 1'($urandom), a, 16'($urandom));
            end
        end
        idle(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shk_reg_slave.md
# shk_reg_slave

Shake-bus responder that terminates master transactions into a local register bank. It accepts single-cycle write/read requests, returns a single-cycle acknowledge carrying address, op-type echo and data, and exposes the bank contents to downstream logic. It sits at the slave end of any shake link, opposite the simulation and real shake masters, replacing the echo-only sim slave in synthesizable designs.

## Interface
- WD_SHK_DATA, 16, shake data width
- WD_SHK_ADDR, 16, shake address width
- NB_REG_ADDR, 4, log2 of register count (16 regs)
- REG_BASE, 16'h0010, address of register 0
- NB_RSP_DELAY, 2, extra wait cycles before acknowledge (0..15)
- WD_ERR_INFO, 4, error info width (≥2)

- i_sys_clk  in  1  system clock
- i_sys_reset  in  1  asynchronous, active-high reset
- s_shk_reg_valid  in  1  request strobe, single cycle
- s_shk_reg_msync  in  1  op qualifier: 1 = write, 0 = read
- s_shk_reg_mdata  in  WD_SHK_DATA  write data
- s_shk_reg_maddr  in  WD_SHK_ADDR  target address
- s_shk_reg_ready  out  1  acknowledge, single cycle
- s_shk_reg_ssync  out  1  op echo (captured msync)
- s_shk_reg_sdata  out  WD_SHK_DATA  register value after access
- s_shk_reg_saddr  out  WD_SHK_ADDR  captured address
- o_reg_bank  out  2**NB_REG_ADDR*WD_SHK_DATA  flat bank, reg i at [i*WD_SHK_DATA +: WD_SHK_DATA]
- o_reg_wstb  out  2**NB_REG_ADDR  one-hot write strobe
- m_err_reg_info1  out  WD_ERR_INFO  sticky error flags

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: on valid, capture msync/maddr/mdata; go WAIT (load delay counter with NB_RSP_DELAY-1) or RESP if NB_RSP_DELAY=0.
- WAIT: decrement counter; at 0 go RESP.
- RESP: ready=1 for exactly one cycle; return to IDLE.
- Hit: REG_BASE ≤ maddr < REG_BASE+2**NB_REG_ADDR; index = (maddr-REG_BASE) truncated to NB_REG_ADDR bits.
- Write hit: register updated on edge entering RESP; o_reg_wstb[index]=1 during RESP; sdata = new value.
- Read hit: sdata = register value; no strobe.
- Miss: no write, no strobe; sdata = all ones; miss flag set.
- valid while not IDLE (including RESP cycle): request dropped, no ready generated for it, overrun flag set.
- ssync/sdata/saddr registered; hold last response between acknowledges.

## Timing
- valid at cycle T -> ready at T+1+NB_RSP_DELAY (default T+3).
- Next request accepted no earlier than the cycle after ready.
- Reset (any time, asynchronous): FSM IDLE, counter 0, bank all 0, ready/ssync/sdata/saddr/wstb/err all 0; in-flight request discarded, no ready after release.
- First request accepted in the first clock with reset deasserted.

## Configuration
- SHK_REG_SLAVE_ERR_INFO_EN defined: m_err_reg_info1[0] = overrun, [1] = address miss, sticky until reset; upper bits 0.
- Undefined: m_err_reg_info1 tied 0; drop/miss behaviour otherwise identical.

## Structure
- Shared package shk_bus_pkg: FSM state encoding, error bit indices, miss data pattern, default widths.
- Sub-module shk_reg_bank: storage, index decode, write strobe generation; FSM and response path stay in top.

## Test plan
- Write 0x1234 to 0x0013 (msync=1) at T -> ready at T+3, ssync=1, saddr=0x0013, sdata=0x1234, o_reg_wstb=0x0008, reg3=0x1234.
- Read 0x0013 after above -> ready at T+3, ssync=0, sdata=0x1234, wstb=0.
- Write 0xBEEF to 0x0020 -> ready, sdata=0xFFFF, bank unchanged, err_info=0b0010 (macro on) / 0 (off).
- Second valid one cycle after first -> only one ready, first transaction completes, err_info[0]=1.
- Reset asserted during WAIT -> no ready, all outputs 0; post-reset read of 0x0010 returns 0x0000.
- NB_RSP_DELAY=0: back-to-back valids spaced 2 cycles -> two readys, each one cycle after its valid, no overrun.
